// File: rtl/axis_status_reader.sv
// AXI4-Stream sink that captures each accepted word into status registers,
// counting words and flagging new data; continuous or single-shot (armed) capture.
module axis_status_reader #(
   parameter int unsigned AXIS_TDATA_WIDTH = 32,
   parameter int unsigned CNTR_WIDTH       = 32
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic                        cfg_mode,
   input  logic                        cfg_arm,
   input  logic                        cfg_clear,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   output logic                        s_axis_tready,
   output logic [AXIS_TDATA_WIDTH-1:0] sts_data,
   output logic                        sts_valid,
   output logic [CNTR_WIDTH-1:0]       sts_cntr
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CONT  = 2'd1;
   localparam logic [1:0] ST_ARMED = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [CNTR_WIDTH-1:0] CNTR_ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]                  state_q, state_d;
   logic [AXIS_TDATA_WIDTH-1:0] data_q, data_d;
   logic                        valid_q, valid_d;
   logic [CNTR_WIDTH-1:0]       cntr_q, cntr_d;
   logic                        tready;
   logic                        hs;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
         cntr_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         cntr_q  <= cntr_d;
      end
   end

   // Mode changes take priority over arm; arm outside IDLE/DONE is dropped.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!cfg_mode)    state_d = ST_CONT;
            else if (cfg_arm) state_d = ST_ARMED;
         end
         ST_CONT: begin
            if (cfg_mode)     state_d = ST_IDLE;
         end
         ST_ARMED: begin
            if (!cfg_mode)    state_d = ST_CONT;
            else if (hs)      state_d = ST_DONE;
         end
         ST_DONE: begin
            if (!cfg_mode)    state_d = ST_CONT;
            else if (cfg_arm) state_d = ST_ARMED;
         end
         default:             state_d = ST_IDLE;
      endcase
   end

   // tready is a pure state decode so it never loops back through tvalid.
   always_comb begin
      tready  = (state_q == ST_CONT) || (state_q == ST_ARMED);
      hs      = s_axis_tvalid && tready;
      data_d  = data_q;
      cntr_d  = cntr_q;
      valid_d = valid_q;
      if (cfg_clear) valid_d = 1'b0;
      if (hs) begin
         data_d  = s_axis_tdata;
         cntr_d  = cntr_q + CNTR_ONE;
         valid_d = 1'b1;
      end
   end

   assign s_axis_tready = tready;
   assign sts_data      = data_q;
   assign sts_valid     = valid_q;
   assign sts_cntr      = cntr_q;

endmodule

// File: tb/tb_axis_status_reader.sv
// Directed bench for axis_status_reader: a 32-bit-counter and a 4-bit-counter
// instance share stimulus; a state model plus expected-word queue checks both.
module tb_axis_status_reader;

   logic        aclk = 1'b0;
   logic        areset;
   logic        cfg_mode, cfg_arm, cfg_clear;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready, t4_tready;
   logic [31:0] sts_data, d4_data;
   logic        sts_valid, v4_valid;
   logic [31:0] sts_cntr;
   logic [3:0]  c4_cntr;

   int checks   = 0;
   int failures = 0;

   logic [1:0]  m_state;
   logic [31:0] m_cntr;
   logic [31:0] m_data;
   logic        m_valid;
   logic [31:0] exp_q[$];

   always #5 aclk = ~aclk;

   axis_status_reader #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(32)) dut (
      .aclk(aclk), .areset(areset), .cfg_mode(cfg_mode), .cfg_arm(cfg_arm),
      .cfg_clear(cfg_clear), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .sts_data(sts_data), .sts_valid(sts_valid),
      .sts_cntr(sts_cntr)
   );

   axis_status_reader #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(4)) dut4 (
      .aclk(aclk), .areset(areset), .cfg_mode(cfg_mode), .cfg_arm(cfg_arm),
      .cfg_clear(cfg_clear), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(t4_tready), .sts_data(d4_data), .sts_valid(v4_valid),
      .sts_cntr(c4_cntr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // 0 IDLE, 1 CONT, 2 ARMED, 3 DONE
   function automatic logic m_ready();
      return (m_state == 2'd1) || (m_state == 2'd2);
   endfunction

   function automatic logic [1:0] m_next(input logic [1:0] s, input logic mode,
                                         input logic arm, input logic hs);
      case (s)
         2'd0:    return !mode ? 2'd1 : (arm ? 2'd2 : 2'd0);
         2'd1:    return mode ? 2'd0 : 2'd1;
         2'd2:    return !mode ? 2'd1 : (hs ? 2'd3 : 2'd2);
         default: return !mode ? 2'd1 : (arm ? 2'd2 : 2'd3);
      endcase
   endfunction

   task automatic m_reset();
      m_state = 2'd0;
      m_cntr  = 0;
      m_data  = 0;
      m_valid = 1'b0;
      exp_q.delete();
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, "_data"},   sts_data,  m_data);
      chk({tag, "_cntr"},   sts_cntr,  m_cntr);
      chk({tag, "_cntr4"},  c4_cntr,   m_cntr[3:0]);
      chk({tag, "_valid"},  sts_valid, m_valid);
   endtask

   // One cycle: drive at negedge, check tready, clock, check status at next negedge.
   task automatic step(input string tag, input logic mode, input logic arm, input logic clr,
                       input logic tv, input logic [31:0] td);
      logic hs;
      cfg_mode      = mode;
      cfg_arm       = arm;
      cfg_clear     = clr;
      s_axis_tvalid = tv;
      s_axis_tdata  = td;
      chk({tag, "_tready"},  s_axis_tready, m_ready());
      chk({tag, "_tready4"}, t4_tready,     m_ready());
      hs = tv && m_ready();
      if (hs) begin
         exp_q.push_back(td);
         m_cntr  = m_cntr + 1;
         m_valid = 1'b1;
      end else if (clr) begin
         m_valid = 1'b0;
      end
      m_state = m_next(m_state, mode, arm, hs);
      @(posedge aclk);
      @(negedge aclk);
      if (hs) begin
         if (exp_q.size() == 0) chk({tag, "_queue"}, 64'd0, 64'd1);
         else m_data = exp_q.pop_front();
      end
      chk_outputs(tag);
   endtask

   initial begin
      areset        = 1'b1;
      cfg_mode      = 1'b0;
      cfg_arm       = 1'b0;
      cfg_clear     = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      m_reset();
      repeat (3) @(negedge aclk);
      chk("rst_tready", s_axis_tready, 1'b0);
      chk_outputs("rst");
      areset = 1'b0;

      // continuous capture, back-to-back words
      step("cont_enter", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step("cont_w1",    1'b0, 1'b0, 1'b0, 1'b1, 32'h11);
      step("cont_w2",    1'b0, 1'b0, 1'b0, 1'b1, 32'h22);
      step("cont_w3",    1'b0, 1'b0, 1'b0, 1'b1, 32'h33);
      step("cont_xdat",  1'b0, 1'b0, 1'b0, 1'b0, 32'hxxxx_xxxx);

      // single-shot: no arm means no capture; one arm takes exactly one word
      step("ss_exit",    1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++)
         step("ss_noarm", 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5);
      step("ss_arm",     1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A5_A5A5);
      step("ss_take",    1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5);
      step("ss_done1",   1'b1, 1'b0, 1'b0, 1'b1, 32'h5A5A_5A5A);
      step("ss_done2",   1'b1, 1'b0, 1'b0, 1'b1, 32'h5A5A_5A5A);
      step("ss_clear",   1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      step("ss_rearm",   1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      step("ss_take2",   1'b1, 1'b1, 1'b0, 1'b1, 32'hC0DE_0001);

      // mode beats arm from DONE, then clear collides with a handshake
      step("prio",       1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      step("clr_hs",     1'b0, 1'b0, 1'b1, 1'b1, 32'h55);
      step("clr_idle",   1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      step("cont_arm",   1'b0, 1'b1, 1'b0, 1'b1, 32'h66);

      // ARMED -> CONT on mode drop, then CONT exit still captures its handshake
      step("ar_idle",    1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step("ar_arm",     1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      step("ar_tocont",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step("ar_exit_hs", 1'b1, 1'b0, 1'b0, 1'b1, 32'h77);
      step("ar_idle2",   1'b1, 1'b0, 1'b0, 1'b1, 32'h88);

      // asynchronous reset between edges while a word is on the bus in CONT
      step("pre_rst",    1'b0, 1'b0, 1'b0, 1'b1, 32'h90);
      step("pre_rst2",   1'b0, 1'b0, 1'b0, 1'b1, 32'h91);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h99;
      #2;
      areset = 1'b1;
      #1;
      m_reset();
      chk("arst_tready", s_axis_tready, 1'b0);
      chk_outputs("arst");
      @(posedge aclk);
      @(negedge aclk);
      chk("arst_hold_tready", s_axis_tready, 1'b0);
      chk_outputs("arst_hold");
      areset        = 1'b0;
      s_axis_tvalid = 1'b0;
      step("post_rst",   1'b0, 1'b0, 1'b0, 1'b1, 32'hAA);

      // 17 handshakes: the 4-bit counter wraps 15 -> 0 -> 1
      for (int i = 1; i <= 17; i++)
         step("wrap", 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000 + 32'(i));
      chk("wrap_cntr4_final", c4_cntr, 4'd1);
      chk("wrap_data4_final", d4_data, 32'h1011);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axis_status_reader.md
Name: axis_status_reader

Overview:
- AXI4-Stream slave that terminates a stream into status registers. It is the receive-side counterpart of the config-to-stream source.
- Each accepted word is latched into sts_data, counted, and flagged as new via a sticky sts_valid. Software clears the flag.
- Supports continuous capture, or single-shot capture armed per word with back-pressure between shots.
- Sits between PL stream producers (e.g. ADC/DSP taps) and the PS-visible status bus.

Parameters:
- AXIS_TDATA_WIDTH, 32, width of stream data and sts_data.
- CNTR_WIDTH, 32, width of the accepted-word counter sts_cntr.

Ports:
- aclk  in  1  system clock; all logic on its rising edge.
- areset  in  1  reset, asynchronous, active-high.
- cfg_mode  in  1  0 = continuous capture, 1 = single-shot capture.
- cfg_arm  in  1  single-cycle pulse; arms one capture in single-shot mode.
- cfg_clear  in  1  single-cycle pulse; clears sts_valid.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- sts_data  out  AXIS_TDATA_WIDTH  last accepted word.
- sts_valid  out  1  sticky flag: a word was accepted since the last clear.
- sts_cntr  out  CNTR_WIDTH  number of accepted words, modulo 2^CNTR_WIDTH.

Behaviour:
- Reset (async assert, release sync to aclk): state IDLE, s_axis_tready 0, sts_data 0, sts_valid 0, sts_cntr 0.
- Handshake: s_axis_tvalid & s_axis_tready in a cycle. The word is taken on that edge. sts_data, sts_cntr and sts_valid update on the same edge, so they are visible the next cycle (latency 1).
- s_axis_tready is decoded only from the registered state: 1 in CONT and ARMED, 0 in IDLE and DONE. It never depends combinationally on s_axis_tvalid.
- FSM states: IDLE, CONT, ARMED, DONE.
  - IDLE: if cfg_mode=0, go to CONT. Else if cfg_arm=1, go to ARMED. Otherwise stay.
  - CONT: if cfg_mode=1, go to IDLE. A handshake in the exit cycle is still captured.
  - ARMED: if cfg_mode=0, go to CONT. Else on handshake, go to DONE.
  - DONE: if cfg_mode=0, go to CONT. Else if cfg_arm=1, go to ARMED.
- cfg_arm in CONT or ARMED is ignored; it is not queued.
- A mode change takes priority over arm in the same cycle.
- In single-shot mode exactly one word is accepted per arm. Upstream is back-pressured in DONE/IDLE, and no data is lost or duplicated.
- sts_data holds the last accepted word indefinitely. It is unaffected by cfg_clear and mode changes.
- sts_cntr increments by 1 per handshake and wraps from all-ones to 0 with no flag.
- sts_valid is set on handshake and cleared by cfg_clear. If both occur in the same cycle, the handshake wins and sts_valid = 1.
- s_axis_tdata is don't-care when no handshake occurs; X on tdata must not propagate.
- Reset mid-transfer aborts immediately: all outputs return to their reset values, and the in-flight word is not counted.
- Throughput in CONT: one word per cycle sustained.

Decomposition:
- Block is self-contained; no shared package needed.
- FSM state encodings are localparams local to the module (2-bit).
- No sub-module: the counter and capture registers are trivial inline logic.

Test Plan:
- Reset then cfg_mode=0, tvalid held 1 with tdata 0x11,0x22,0x33 on consecutive cycles -> tready=1 from the second cycle after reset release; sts_data 0x11,0x22,0x33 each one cycle later; sts_cntr 1,2,3; sts_valid=1.
- cfg_mode=1, tvalid=1 with tdata=0xA5A5A5A5 and no arm -> tready stays 0, sts_cntr unchanged. Pulse cfg_arm -> exactly one word is accepted, sts_data=0xA5A5A5A5, cntr +1, state DONE with tready=0.
- cfg_clear pulse in the same cycle as a CONT handshake -> sts_valid stays 1. A clear on an idle cycle afterwards -> sts_valid=0 next cycle.
- CNTR_WIDTH=4, 17 handshakes in CONT -> sts_cntr goes 15 -> 0 -> 1; sts_data equals the 17th word.
- In ARMED, switch cfg_mode to 0 while tvalid=0 -> state CONT, tready stays 1. Switch back to 1 in the same cycle as a handshake -> word is captured, then IDLE with tready=0.
- Assert areset mid-stream in CONT (asynchronously, between edges) -> tready, sts_valid, sts_cntr and sts_data drop to 0 immediately. No capture occurs until release, followed by re-entry to CONT.
